// File: rtl/input_controller_xy.sv
// input_controller_xy
//   Router input-port controller for the mesh NoC. Pops flits from a show-ahead
//   input FIFO, decodes the XY route of each head flit and holds a one-hot
//   request towards the output-port arbiters until the packet's tail flit has
//   been forwarded (wormhole lock). Forwarded flits leave through a register.
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   Data_in, empty    FIFO head word and FIFO-empty flag
//   read              FIFO pop (combinational)
//   req               one-hot output request: 0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH
//   grant             arbiter grant + downstream ready for this cycle
//   Data_out          forwarded flit (registered), qualified by valid_out
//   err               one-cycle pulse when a non-head flit is dropped in IDLE
//   pkt_cnt           count of forwarded tail/single flits, wraps
module input_controller_xy #(
    parameter int DATA_WIDTH = 16,
    parameter int COORD_W    = 2,
    parameter int MY_X       = 0,
    parameter int MY_Y       = 0,
    parameter int N_REQ      = 5,
    parameter int PKT_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  empty,
    output logic                  read,
    output logic [N_REQ-1:0]      req,
    input  logic                  grant,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  valid_out,
    output logic                  err,
    output logic [PKT_CNT_W-1:0]  pkt_cnt
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [COORD_W-1:0] MY_X_C = COORD_W'(MY_X);
    localparam logic [COORD_W-1:0] MY_Y_C = COORD_W'(MY_Y);

    state_t                state_q, state_d;
    logic [N_REQ-1:0]      req_q, req_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  err_q, err_d;
    logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

    logic [1:0]            flit_type;
    logic [COORD_W-1:0]    dest_x, dest_y;
    logic                  is_head, is_last, read_int;
    logic [N_REQ-1:0]      route;

    assign flit_type = Data_in[DATA_WIDTH-1 -: 2];
    assign dest_x    = Data_in[DATA_WIDTH-3 -: COORD_W];
    assign dest_y    = Data_in[DATA_WIDTH-3-COORD_W -: COORD_W];
    // Type bit 0 marks a packet start (head/single), bit 1 a packet end (tail/single).
    assign is_head   = flit_type[0];
    assign is_last   = flit_type[1];

    // Dimension-ordered routing: resolve X completely before Y.
    always_comb begin
        route = '0;
        if (dest_x > MY_X_C) begin
            route[1] = 1'b1;
        end else if (dest_x < MY_X_C) begin
            route[2] = 1'b1;
        end else if (dest_y > MY_Y_C) begin
            route[3] = 1'b1;
        end else if (dest_y < MY_Y_C) begin
            route[4] = 1'b1;
        end else begin
            route[0] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        err_d       = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        read_int    = 1'b0;
        case (state_q)
            IDLE: begin
                req_d = '0;
                if (!empty) begin
                    if (is_head) begin
                        // Head stays in the FIFO; it is popped as the first flit of ACTIVE.
                        req_d   = route;
                        state_d = ACTIVE;
                    end else begin
                        read_int = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                read_int = grant & ~empty;
                if (read_int) begin
                    data_out_d  = Data_in;
                    valid_out_d = 1'b1;
                    if (is_last) begin
                        state_d   = IDLE;
                        req_d     = '0;
                        pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            err_q       <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Pop is forced low while reset is held so the FIFO is not drained during reset.
    assign read      = read_int & rst_n;
    assign req       = req_q;
    assign Data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign err       = err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_input_controller_xy.sv
module tb_input_controller_xy;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] Data_in = '0;
    logic        empty = 1'b1;
    logic        read;
    logic [4:0]  req;
    logic        grant = 1'b0;
    logic [15:0] Data_out;
    logic        valid_out;
    logic        err;
    logic [1:0]  pkt_cnt;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] fifo_q[$];
    logic        hide = 1'b0;

    input_controller_xy #(
        .DATA_WIDTH(16),
        .COORD_W   (2),
        .MY_X      (1),
        .MY_Y      (1),
        .N_REQ     (5),
        .PKT_CNT_W (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Data_in  (Data_in),
        .empty    (empty),
        .read     (read),
        .req      (req),
        .grant    (grant),
        .Data_out (Data_out),
        .valid_out(valid_out),
        .err      (err),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic [1:0] t, input logic [1:0] x,
                                       input logic [1:0] y, input logic [9:0] p);
        return {t, x, y, p};
    endfunction

    task automatic drive_fifo();
        empty   = hide || (fifo_q.size() == 0);
        Data_in = (fifo_q.size() != 0) ? fifo_q[0] : 16'h0000;
    endtask

    // One clock: inputs set after the previous edge, read sampled at the negedge,
    // FIFO popped and outputs observable #1 after the posedge.
    task automatic step(input logic g, input logic h, output logic rd);
        grant = g;
        hide  = h;
        drive_fifo();
        @(negedge clk);
        rd = read;
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        hide = 1'b0;
        drive_fifo();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        fifo_q.delete();
        grant = 1'b0;
        hide  = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        fifo_q.delete();
        fifo_q.push_back(mk(2'b00, 2'd0, 2'd0, 10'h011));
        rst_n = 1'b0;
        drive_fifo();
        #1;
        compared++; if (read !== 1'b0) begin mismatched++; $display("FAIL reset_read got %b exp 0", read); end
        compared++; if (req !== 5'b00000) begin mismatched++; $display("FAIL reset_req got %b exp 00000", req); end
        compared++; if (Data_out !== 16'h0000) begin mismatched++; $display("FAIL reset_data got %h exp 0000", Data_out); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b exp 0", valid_out); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err got %b exp 0", err); end
        compared++; if (pkt_cnt !== 2'd0) begin mismatched++; $display("FAIL reset_pkt got %0d exp 0", pkt_cnt); end
    endtask

    task automatic test_packet();
        logic        rd;
        logic [15:0] h, b, t;
        logic        e_rd[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  e_req[5] = '{5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
        logic [15:0] e_dat[5];
        h = mk(2'b01, 2'd3, 2'd1, 10'h0A1);
        b = mk(2'b00, 2'd0, 2'd0, 10'h0B2);
        t = mk(2'b10, 2'd0, 2'd0, 10'h0C3);
        e_dat = '{16'h0000, h, b, t, t};
        apply_reset();
        fifo_q.push_back(h); fifo_q.push_back(b); fifo_q.push_back(t);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, rd);
            compared++; if (rd !== e_rd[i]) begin mismatched++; $display("FAIL pkt_read[%0d] got %b exp %b", i, rd, e_rd[i]); end
            compared++; if (req !== e_req[i]) begin mismatched++; $display("FAIL pkt_req[%0d] got %b exp %b", i, req, e_req[i]); end
            compared++; if (valid_out !== e_rd[i]) begin mismatched++; $display("FAIL pkt_valid[%0d] got %b exp %b", i, valid_out, e_rd[i]); end
            compared++; if (Data_out !== e_dat[i]) begin mismatched++; $display("FAIL pkt_data[%0d] got %h exp %h", i, Data_out, e_dat[i]); end
        end
        compared++; if (pkt_cnt !== 2'd1) begin mismatched++; $display("FAIL pkt_cnt got %0d exp 1", pkt_cnt); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL pkt_err got %b exp 0", err); end
    endtask

    task automatic test_stall();
        logic        rd;
        logic [15:0] h, b, t;
        logic        g[6]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        hd[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        e_rd[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [4:0]  e_req[6] = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
        logic [15:0] e_dat[6];
        h = mk(2'b01, 2'd3, 2'd1, 10'h1A1);
        b = mk(2'b00, 2'd2, 2'd2, 10'h1B2);
        t = mk(2'b10, 2'd1, 2'd3, 10'h1C3);
        e_dat = '{16'h0000, h, h, h, b, t};
        apply_reset();
        fifo_q.push_back(h); fifo_q.push_back(b); fifo_q.push_back(t);
        for (int i = 0; i < 6; i++) begin
            step(g[i], hd[i], rd);
            compared++; if (rd !== e_rd[i]) begin mismatched++; $display("FAIL stall_read[%0d] got %b exp %b", i, rd, e_rd[i]); end
            compared++; if (req !== e_req[i]) begin mismatched++; $display("FAIL stall_req[%0d] got %b exp %b", i, req, e_req[i]); end
            compared++; if (valid_out !== e_rd[i]) begin mismatched++; $display("FAIL stall_valid[%0d] got %b exp %b", i, valid_out, e_rd[i]); end
            compared++; if (Data_out !== e_dat[i]) begin mismatched++; $display("FAIL stall_data[%0d] got %h exp %h", i, Data_out, e_dat[i]); end
        end
        compared++; if (pkt_cnt !== 2'd1) begin mismatched++; $display("FAIL stall_pkt got %0d exp 1", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        logic        rd;
        logic [15:0] s[4];
        logic [4:0]  e_req[8] = '{5'b00001, 5'b00000, 5'b00100, 5'b00000,
                                  5'b01000, 5'b00000, 5'b10000, 5'b00000};
        logic [1:0]  e_pkt[8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        logic [15:0] e_dat[8];
        logic        e_rd;
        s[0] = mk(2'b11, 2'd1, 2'd1, 10'h201);
        s[1] = mk(2'b11, 2'd0, 2'd2, 10'h202);
        s[2] = mk(2'b11, 2'd1, 2'd2, 10'h203);
        s[3] = mk(2'b11, 2'd1, 2'd0, 10'h204);
        e_dat = '{16'h0000, s[0], s[0], s[1], s[1], s[2], s[2], s[3]};
        apply_reset();
        for (int k = 0; k < 4; k++) fifo_q.push_back(s[k]);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, rd);
            e_rd = (i % 2) == 1;
            compared++; if (rd !== e_rd) begin mismatched++; $display("FAIL b2b_read[%0d] got %b exp %b", i, rd, e_rd); end
            compared++; if (req !== e_req[i]) begin mismatched++; $display("FAIL b2b_req[%0d] got %b exp %b", i, req, e_req[i]); end
            compared++; if (valid_out !== e_rd) begin mismatched++; $display("FAIL b2b_valid[%0d] got %b exp %b", i, valid_out, e_rd); end
            compared++; if (Data_out !== e_dat[i]) begin mismatched++; $display("FAIL b2b_data[%0d] got %h exp %h", i, Data_out, e_dat[i]); end
            compared++; if (pkt_cnt !== e_pkt[i]) begin mismatched++; $display("FAIL b2b_pkt[%0d] got %0d exp %0d", i, pkt_cnt, e_pkt[i]); end
        end
    endtask

    task automatic test_drop();
        logic rd;
        apply_reset();
        fifo_q.push_back(mk(2'b00, 2'd3, 2'd3, 10'h301));
        step(1'b1, 1'b0, rd);
        compared++; if (rd !== 1'b1) begin mismatched++; $display("FAIL drop_read got %b exp 1", rd); end
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL drop_err got %b exp 1", err); end
        compared++; if (req !== 5'b00000) begin mismatched++; $display("FAIL drop_req got %b exp 00000", req); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL drop_valid got %b exp 0", valid_out); end
        compared++; if (Data_out !== 16'h0000) begin mismatched++; $display("FAIL drop_data got %h exp 0000", Data_out); end
        step(1'b1, 1'b0, rd);
        compared++; if (rd !== 1'b0) begin mismatched++; $display("FAIL drop_read2 got %b exp 0", rd); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL drop_err2 got %b exp 0", err); end
    endtask

    task automatic test_reset_mid();
        logic        rd;
        logic [15:0] h, b1;
        h  = mk(2'b01, 2'd3, 2'd1, 10'h3A1);
        b1 = mk(2'b00, 2'd0, 2'd0, 10'h3B1);
        apply_reset();
        fifo_q.push_back(h);
        fifo_q.push_back(b1);
        fifo_q.push_back(mk(2'b00, 2'd0, 2'd0, 10'h3B2));
        fifo_q.push_back(mk(2'b10, 2'd0, 2'd0, 10'h3C3));
        step(1'b1, 1'b0, rd);
        step(1'b1, 1'b0, rd);
        step(1'b1, 1'b0, rd);
        compared++; if (Data_out !== b1 || valid_out !== 1'b1) begin mismatched++; $display("FAIL mid_pre got %h/%b exp %h/1", Data_out, valid_out, b1); end
        rst_n = 1'b0;
        #1;
        compared++; if (req !== 5'b00000) begin mismatched++; $display("FAIL mid_req got %b exp 00000", req); end
        compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b exp 0", valid_out); end
        compared++; if (Data_out !== 16'h0000) begin mismatched++; $display("FAIL mid_data got %h exp 0000", Data_out); end
        compared++; if (read !== 1'b0) begin mismatched++; $display("FAIL mid_read got %b exp 0", read); end
        hide = 1'b1;
        drive_fifo();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, rd);
            compared++; if (rd !== 1'b1) begin mismatched++; $display("FAIL mid_drop_read[%0d] got %b exp 1", i, rd); end
            compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL mid_drop_err[%0d] got %b exp 1", i, err); end
            compared++; if (valid_out !== 1'b0) begin mismatched++; $display("FAIL mid_drop_valid[%0d] got %b exp 0", i, valid_out); end
        end
        step(1'b1, 1'b0, rd);
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL mid_err_end got %b exp 0", err); end
        compared++; if (pkt_cnt !== 2'd0) begin mismatched++; $display("FAIL mid_pkt got %0d exp 0", pkt_cnt); end
        compared++; if (req !== 5'b00000) begin mismatched++; $display("FAIL mid_req_end got %b exp 00000", req); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_stall();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
